// File: rtl/alu_pkg.sv
// Shared constants for the signed ALU result path: source-unit tags and
// the default result widths of the four ALU units.
package alu_pkg;

    typedef enum logic [1:0] {
        TAG_ARITH = 2'b00,
        TAG_LOGIC = 2'b01,
        TAG_CMP   = 2'b10,
        TAG_SHIFT = 2'b11
    } tag_e;

    localparam int TAG_W       = 2;
    localparam int ARITH_OUT_W = 32;
    localparam int LOGIC_OUT_W = 16;
    localparam int CMP_OUT_W   = 2;
    localparam int SHIFT_OUT_W = 17;

endpackage

// File: rtl/sync_fifo.sv
// Generic circular-buffer FIFO with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // The count tops out at DEPTH = 2**PTR_W, so its MSB alone marks full.
    assign o_full    = r_count[PTR_W];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the count qualifies it, and the output mux forces zero while empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/alu_result_fifo.sv
// Collects the one valid ALU unit result per cycle, tags and packs it, and
// buffers it for a valid/ready consumer; overflow and multi-flag cycles are counted.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int Arith_Out_WIDTH = ARITH_OUT_W,
    parameter int Logic_Out_WIDTH = LOGIC_OUT_W,
    parameter int CMP_Out_WIDTH   = CMP_OUT_W,
    parameter int Shift_Out_WIDTH = SHIFT_OUT_W,
    parameter int FIFO_DEPTH      = 4,
    parameter int DROP_CNT_WIDTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [Arith_Out_WIDTH-1:0]    Arith_OUT,
    input  logic [Logic_Out_WIDTH-1:0]    Logic_OUT,
    input  logic [CMP_Out_WIDTH-1:0]      CMP_OUT,
    input  logic [Shift_Out_WIDTH-1:0]    SHIFT_OUT,
    input  logic                          Arith_Flag,
    input  logic                          Logic_Flag,
    input  logic                          CMP_Flag,
    input  logic                          SHIFT_Flag,
    output logic                          RES_VALID,
    input  logic                          RES_READY,
    output logic [Arith_Out_WIDTH-1:0]    RES_DATA,
    output logic [1:0]                    RES_TAG,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic [DROP_CNT_WIDTH-1:0]     DROP_CNT,
    output logic                          MULTI_ERR
);

    localparam int ENTRY_W = TAG_W + Arith_Out_WIDTH;

    logic [3:0]                   w_flags;
    logic                         w_push_req;
    logic                         w_multi;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_drop;
    logic [Arith_Out_WIDTH-1:0]   w_pack_data;
    tag_e                         w_pack_tag;
    logic [ENTRY_W-1:0]           w_head;
    logic [DROP_CNT_WIDTH-1:0]    r_drop_cnt;
    logic                         r_multi_err;

    assign w_flags    = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    assign w_push_req = $onehot(w_flags);
    assign w_multi    = (|w_flags) && !w_push_req;

    // Narrow results are zero-extended; the shift MSB is carry-out, not a sign.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_pack_data = '0;
        w_pack_tag  = TAG_ARITH;
        if (Arith_Flag) begin
            w_pack_data = Arith_OUT;
        end else if (Logic_Flag) begin
            w_pack_data[Logic_Out_WIDTH-1:0] = Logic_OUT;
            w_pack_tag                       = TAG_LOGIC;
        end else if (CMP_Flag) begin
            w_pack_data[CMP_Out_WIDTH-1:0] = CMP_OUT;
            w_pack_tag                     = TAG_CMP;
        end else if (SHIFT_Flag) begin
            w_pack_data[Shift_Out_WIDTH-1:0] = SHIFT_OUT;
            w_pack_tag                       = TAG_SHIFT;
        end
    end

    assign w_pop  = RES_VALID && RES_READY;
    assign w_drop = w_push_req && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_data  ({w_pack_tag, w_pack_data}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (FIFO_COUNT)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_drop_cnt  <= '0;
            r_multi_err <= 1'b0;
        end else begin
            if ((w_multi || w_drop) && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_multi) r_multi_err <= 1'b1;
        end
    end

    assign RES_VALID = !w_empty;
    assign RES_DATA  = w_head[Arith_Out_WIDTH-1:0];
    assign RES_TAG   = w_head[ENTRY_W-1 -: TAG_W];
    assign DROP_CNT  = r_drop_cnt;
    assign MULTI_ERR = r_multi_err;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: expected entries are queued as stimulus
// is driven and compared against the head entry every cycle it is valid.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Arith_OUT = '0;
    logic [15:0] Logic_OUT = '0;
    logic [1:0]  CMP_OUT = '0;
    logic [16:0] SHIFT_OUT = '0;
    logic        Arith_Flag = 1'b0;
    logic        Logic_Flag = 1'b0;
    logic        CMP_Flag = 1'b0;
    logic        SHIFT_Flag = 1'b0;
    logic        RES_READY = 1'b0;
    logic        RES_VALID;
    logic [31:0] RES_DATA;
    logic [1:0]  RES_TAG;
    logic [2:0]  FIFO_COUNT;
    logic [7:0]  DROP_CNT;
    logic        MULTI_ERR;

    always #5 CLK = ~CLK;

    alu_result_fifo dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Logic_OUT  (Logic_OUT),
        .CMP_OUT    (CMP_OUT),
        .SHIFT_OUT  (SHIFT_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_Flag (SHIFT_Flag),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .RES_DATA   (RES_DATA),
        .RES_TAG    (RES_TAG),
        .FIFO_COUNT (FIFO_COUNT),
        .DROP_CNT   (DROP_CNT),
        .MULTI_ERR  (MULTI_ERR)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] sb_q[$];
    int          m_drop = 0;
    logic        m_multi = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] pack(input logic [3:0] flags, input logic [31:0] a,
                                         input logic [15:0] l, input logic [1:0] c,
                                         input logic [16:0] s);
        case (flags)
            4'b0001: return {2'b00, a};
            4'b0010: return {2'b01, 16'h0, l};
            4'b0100: return {2'b10, 30'h0, c};
            default: return {2'b11, 15'h0, s};
        endcase
    endfunction

    task automatic drop_inc();
        if (m_drop < 255) m_drop++;
    endtask

    // Entered and left at a falling edge; checks pre-edge state, updates the model, clocks once.
    task automatic cycle(input logic [3:0] flags, input logic [31:0] a, input logic [15:0] l,
                         input logic [1:0] c, input logic [16:0] s, input logic rdy);
        bit full_before;
        bit pop;
        Arith_Flag = flags[0];
        Logic_Flag = flags[1];
        CMP_Flag   = flags[2];
        SHIFT_Flag = flags[3];
        Arith_OUT  = a;
        Logic_OUT  = l;
        CMP_OUT    = c;
        SHIFT_OUT  = s;
        RES_READY  = rdy;
        #1;
        check("valid", RES_VALID, sb_q.size() != 0);
        check("count", FIFO_COUNT, sb_q.size());
        check("drop_cnt", DROP_CNT, m_drop);
        check("multi_err", MULTI_ERR, m_multi);
        if (sb_q.size() != 0) begin
            check("head_data", RES_DATA, sb_q[0][31:0]);
            check("head_tag", RES_TAG, sb_q[0][33:32]);
        end
        full_before = (sb_q.size() == DEPTH);
        pop = rdy && (sb_q.size() != 0);
        if (pop) void'(sb_q.pop_front());
        if ($onehot(flags)) begin
            if (full_before && !pop) drop_inc();
            else sb_q.push_back(pack(flags, a, l, c, s));
        end else if (flags != 4'b0000) begin
            m_multi = 1'b1;
            drop_inc();
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input logic rdy);
        cycle(4'b0000, '0, '0, '0, '0, rdy);
    endtask

    task automatic reset_and_check(input string tag);
        Arith_Flag = 1'b0;
        Logic_Flag = 1'b0;
        CMP_Flag   = 1'b0;
        SHIFT_Flag = 1'b0;
        RES_READY  = 1'b0;
        RST = 1'b1;
        #1;
        check({tag, "_valid"}, RES_VALID, 0);
        check({tag, "_count"}, FIFO_COUNT, 0);
        check({tag, "_drop"}, DROP_CNT, 0);
        check({tag, "_multi"}, MULTI_ERR, 0);
        check({tag, "_data"}, RES_DATA, 0);
        check({tag, "_tag"}, RES_TAG, 0);
        @(negedge CLK);
        RST = 1'b0;
        sb_q.delete();
        m_drop  = 0;
        m_multi = 1'b0;
    endtask

    initial begin
        #2;
        reset_and_check("rst_init");

        // Single arith result, then one pop.
        cycle(4'b0001, 32'hFFFF_FFFB, '0, '0, '0, 1'b0);
        check("arith_valid", RES_VALID, 1);
        check("arith_data", RES_DATA, 32'hFFFF_FFFB);
        check("arith_tag", RES_TAG, 2'b00);
        check("arith_count", FIFO_COUNT, 1);
        idle(1'b1);
        check("arith_popped", RES_VALID, 0);

        // Zero extension of shift and compare results.
        cycle(4'b1000, '0, '0, '0, 17'h1FFFF, 1'b0);
        check("shift_data", RES_DATA, 32'h0001_FFFF);
        check("shift_tag", RES_TAG, 2'b11);
        cycle(4'b0100, '0, '0, 2'b10, '0, 1'b1);
        check("cmp_data", RES_DATA, 32'h0000_0002);
        check("cmp_tag", RES_TAG, 2'b10);
        idle(1'b1);
        check("zext_drained", RES_VALID, 0);

        // Overflow with the consumer stalled, then drain in order.
        reset_and_check("rst_ovf");
        for (int i = 1; i <= 6; i++) cycle(4'b0010, '0, 16'(i), '0, '0, 1'b0);
        check("ovf_count", FIFO_COUNT, 4);
        check("ovf_drop", DROP_CNT, 2);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("ovf_drained", RES_VALID, 0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) cycle(4'b0010, '0, 16'h11 + 16'(i), '0, '0, 1'b0);
        cycle(4'b0010, '0, 16'h00AA, '0, '0, 1'b1);
        check("full_pp_count", FIFO_COUNT, 4);
        check("full_pp_drop", DROP_CNT, 2);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("aa_fourth", RES_DATA, 32'h0000_00AA);
        idle(1'b1);

        // Multiple flags in one cycle.
        cycle(4'b0101, 32'h1234, '0, 2'b01, '0, 1'b0);
        check("multi_set", MULTI_ERR, 1);
        check("multi_drop", DROP_CNT, 3);
        check("multi_nopush", FIFO_COUNT, 0);
        cycle(4'b0010, '0, 16'h0055, '0, '0, 1'b0);
        idle(1'b1);
        check("multi_sticky", MULTI_ERR, 1);

        // Reset mid-stream with stored entries and a non-zero drop count.
        reset_and_check("rst_pre");
        for (int i = 0; i < 3; i++) cycle(4'b0001, 32'hA0 + 32'(i), '0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b1001, '0, '0, '0, '0, 1'b0);
        check("pre_rst_count", FIFO_COUNT, 3);
        check("pre_rst_drop", DROP_CNT, 5);
        reset_and_check("rst_mid");

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) cycle(4'b0011, '0, '0, '0, '0, 1'b0);
        check("drop_sat", DROP_CNT, 255);
        reset_and_check("rst_rand");

        // Randomised mix of pushes, multi-flag cycles and consumer stalls.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            int unsigned u;
            int unsigned v;
            logic [3:0] flags;
            r = $urandom_range(0, 9);
            u = $urandom_range(0, 3);
            if (r < 6) flags = 4'(1 << u);
            else if (r == 6) begin
                v = (u + 1 + $urandom_range(0, 2)) % 4;
                flags = 4'((1 << u) | (1 << v));
            end else flags = 4'b0000;
            cycle(flags, $urandom, 16'($urandom), 2'($urandom), 17'($urandom),
                  (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
